// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, fixed latency of
// WIDTH cycles, signed operands handled by sign-magnitude with a final negate.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk1,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               neg_q, neg_d;
  logic               sop_q, sop_d;
  logic [PW-1:0]      product_q, product_d;
  logic               overflow_q, overflow_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [PW-1:0]      acc_sum;
  logic [PW-1:0]      prod_final;
  logic               ovf_final;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exactly right as an unsigned magnitude.
  assign abs_a = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b = (signed_op && b[WIDTH-1]) ? -b : b;

  // mag_a walks left and mag_b walks right, so bit 0 of mag_b is always mag_b[counter].
  assign acc_sum    = acc_q + (mag_b_q[0] ? mag_a_q : '0);
  assign prod_final = neg_q ? -acc_sum : acc_sum;
  assign ovf_final  = sop_q ? (prod_final[PW-1:WIDTH] != {WIDTH{prod_final[WIDTH-1]}})
                            : (|prod_final[PW-1:WIDTH]);

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    neg_d      = neg_q;
    sop_d      = sop_q;
    product_d  = product_q;
    overflow_d = overflow_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = '0;
          mag_a_d = {{WIDTH{1'b0}}, abs_a};
          mag_b_d = abs_b;
          neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          sop_d   = signed_op;
        end
      end

      S_RUN: begin
        acc_d   = acc_sum;
        mag_a_d = mag_a_q << 1;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d    = S_DONE;
          product_d  = prod_final;
          overflow_d = ovf_final;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      neg_q      <= 1'b0;
      sop_q      <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      neg_q      <= neg_d;
      sop_q      <= sop_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised and directed checks of seq_multiplier against a plain-arithmetic
// reference product, including latency, hold, busy-drop and reset-abort behaviour.
module tb_seq_multiplier;

  localparam int WIDTH = 32;

  logic              clk1 = 1'b0;
  logic              reset;
  logic              start;
  logic              signed_op;
  logic [WIDTH-1:0]  a, b;
  logic              busy, done;
  logic [2*WIDTH-1:0] product;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*WIDTH-1:0] last_prod = '0;
  logic               last_ovf  = 1'b0;

  seq_multiplier #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk1      (clk1),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .overflow  (overflow)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Reference: full product by ordinary 64-bit arithmetic, overflow by range test.
  task automatic ref_model(input logic [31:0] ia, input logic [31:0] ib, input logic isop,
                           output logic [63:0] p, output logic ov);
    longint sa, sb, sp;
    longint unsigned ua, ub;
    if (isop) begin
      sa = longint'($signed(ia));
      sb = longint'($signed(ib));
      sp = sa * sb;
      p  = sp;
      ov = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
    end else begin
      ua = {32'd0, ia};
      ub = {32'd0, ib};
      p  = ua * ub;
      ov = (p >> 32) != 0;
    end
  endtask

  // Launch one multiply and follow it to completion; optionally pulse a second start
  // while busy, which must be ignored.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isop,
                        input bit inject, input bit detailed);
    logic [63:0] exp_p;
    logic        exp_ov;
    int          cyc;
    ref_model(ia, ib, isop, exp_p, exp_ov);
    a = ia; b = ib; signed_op = isop; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; signed_op = 1'($urandom);
    if (detailed) begin
      check("busy_after_accept", 64'(busy), 64'd1);
      check("done_drop_after_accept", 64'(done), 64'd0);
      check("product_hold", product, last_prod);
      check("overflow_hold", 64'(overflow), 64'(last_ovf));
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (inject && cyc == 9) begin
        start = 1'b1; a = 32'd9; b = 32'd9; signed_op = 1'b0;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    check("latency", 64'(cyc), 64'd32);
    check("product", product, exp_p);
    check("overflow", 64'(overflow), 64'(exp_ov));
    if (detailed) check("busy_at_done", 64'(busy), 64'd0);
    last_prod = exp_p;
    last_ovf  = exp_ov;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);

    run_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b1);
    check("unsigned_basic_literal", product, 64'h0000_0000_0000_002A);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 1'b1);
    check("signed_mixed_literal", product, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    check("most_negative_literal", product, 64'h4000_0000_0000_0000);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    check("unsigned_max_literal", product, 64'hFFFF_FFFE_0000_0001);
    run_op(32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1);
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1);
    run_op(32'd3, 32'd4, 1'b0, 1'b1, 1'b1);
    check("ignored_start_literal", product, 64'd12);

    // Abort mid-operation: the partial result must be discarded.
    a = 32'd100; b = 32'd100; signed_op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    tick();
    check("abort_stays_idle", 64'({busy, done}), 64'd0);
    last_prod = '0;
    last_ovf  = 1'b0;

    run_op(32'd2, 32'd3, 1'b0, 1'b0, 1'b1);
    run_op(32'd10, 32'd10, 1'b0, 1'b0, 1'b1);
    check("back_to_back_literal", product, 64'd100);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op(ra, rb, rs, (i % 7) == 3, (i % 5) == 0);
    end

    // Start held high in DONE relaunches immediately.
    a = 32'd5; b = 32'd5; signed_op = 1'b0; start = 1'b1;
    repeat (33) tick();
    check("held_start_done", 64'(done), 64'd1);
    check("held_start_product", product, 64'd25);
    tick();
    check("held_start_relaunch", 64'(busy), 64'd1);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
